// File: rtl/rect_overlay_draw.sv
// rect_overlay_draw
// Single-cycle in-line stage that paints the detector's bounding box as a
// coloured border onto an RGB888 pixel stream. The box is latched at the
// start of each frame. A valid box stays drawn for HOLD_FRAMES further frames
// after the detector stops reporting one, so the border does not flicker.
module rect_overlay_draw #(
    parameter logic [10:0] IMG_HDISP   = 11'd1024,
    parameter logic [10:0] IMG_VDISP   = 11'd768,
    parameter logic [3:0]  LINE_W      = 4'd2,
    parameter logic [23:0] BOX_COLOR   = 24'hFF0000,
    parameter logic [3:0]  HOLD_FRAMES = 4'd3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        per_frame_vsync,
    input  logic        per_frame_href,
    input  logic        per_frame_clken,
    input  logic [23:0] per_img_data,
    input  logic [10:0] rect_up,
    input  logic [10:0] rect_down,
    input  logic [10:0] rect_left,
    input  logic [10:0] rect_right,
    input  logic        rect_flag,
    input  logic        overlay_en,
    output logic        post_frame_vsync,
    output logic        post_frame_href,
    output logic        post_frame_clken,
    output logic [23:0] post_img_data
);

    // Pixel position within the current frame
    logic [10:0] x_cnt_reg;
    logic [10:0] y_cnt_reg;

    // Frame-latched box state
    logic        vsync_d_reg;
    logic [10:0] up_reg;
    logic [10:0] down_reg;
    logic [10:0] left_reg;
    logic [10:0] right_reg;
    logic        draw_act_reg;
    logic [3:0]  hold_cnt_reg;

    logic        vsync_rise;
    logic        box_ok;

    // Hit-test intermediates, widened by one bit so "+ LINE_W" cannot wrap
    logic [11:0] x_ext;
    logic [11:0] y_ext;
    logic [11:0] lw_ext;
    logic [11:0] up_ext;
    logic [11:0] down_ext;
    logic [11:0] left_ext;
    logic [11:0] right_ext;
    logic        in_box;
    logic        on_edge;
    logic        hit;

    assign vsync_rise = per_frame_vsync & ~vsync_d_reg;
    assign box_ok     = rect_flag && (rect_up <= rect_down) && (rect_left <= rect_right);

    // Raster counters: vsync restarts the frame, y saturates past the last line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt_reg <= 11'd0;
            y_cnt_reg <= 11'd0;
        end else if (per_frame_vsync) begin
            x_cnt_reg <= 11'd0;
            y_cnt_reg <= 11'd0;
        end else if (per_frame_clken) begin
            if (x_cnt_reg == IMG_HDISP - 11'd1) begin
                x_cnt_reg <= 11'd0;
                if (y_cnt_reg < IMG_VDISP) begin
                    y_cnt_reg <= y_cnt_reg + 11'd1;
                end
            end else begin
                x_cnt_reg <= x_cnt_reg + 11'd1;
            end
        end
    end

    // Latch a new box at frame start, or run down the hold counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d_reg  <= 1'b0;
            up_reg       <= 11'd0;
            down_reg     <= 11'd0;
            left_reg     <= 11'd0;
            right_reg    <= 11'd0;
            draw_act_reg <= 1'b0;
            hold_cnt_reg <= 4'd0;
        end else begin
            vsync_d_reg <= per_frame_vsync;
            if (vsync_rise) begin
                if (box_ok) begin
                    up_reg       <= rect_up;
                    down_reg     <= rect_down;
                    left_reg     <= rect_left;
                    right_reg    <= rect_right;
                    hold_cnt_reg <= HOLD_FRAMES;
                    draw_act_reg <= 1'b1;
                end else if (hold_cnt_reg != 4'd0) begin
                    hold_cnt_reg <= hold_cnt_reg - 4'd1;
                end else begin
                    draw_act_reg <= 1'b0;
                end
            end
        end
    end

    // Border hit test on the current pixel position
    always_comb begin
        x_ext     = {1'b0, x_cnt_reg};
        y_ext     = {1'b0, y_cnt_reg};
        lw_ext    = {8'd0, LINE_W};
        up_ext    = {1'b0, up_reg};
        down_ext  = {1'b0, down_reg};
        left_ext  = {1'b0, left_reg};
        right_ext = {1'b0, right_reg};

        in_box  = (y_ext >= up_ext) && (y_ext <= down_ext) &&
                  (x_ext >= left_ext) && (x_ext <= right_ext);
        on_edge = (x_ext < left_ext + lw_ext) || (x_ext + lw_ext > right_ext) ||
                  (y_ext < up_ext + lw_ext)   || (y_ext + lw_ext > down_ext);
        // A pixel arriving with vsync belongs to no frame position; pass it as-is
        hit     = overlay_en && draw_act_reg && in_box && on_edge &&
                  (y_cnt_reg < IMG_VDISP) && !per_frame_vsync;
    end

    // One-cycle output register for syncs and overlaid pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_frame_clken <= 1'b0;
            post_img_data    <= 24'd0;
        end else begin
            post_frame_vsync <= per_frame_vsync;
            post_frame_href  <= per_frame_href;
            post_frame_clken <= per_frame_clken;
            if (per_frame_clken) begin
                post_img_data <= hit ? BOX_COLOR : per_img_data;
            end else begin
                post_img_data <= 24'd0;
            end
        end
    end

endmodule
